// File: rtl/wave_display.sv
// rtl/wave_display.sv - draws a 256-sample trace from the idle half of the capture RAM into a 512x512 window
module wave_display #(
    parameter logic [10:0] X_START    = 11'd256,
    parameter logic [23:0] WAVE_COLOR = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR   = 24'h000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] x,
    input  logic [9:0]  y,
    input  logic        valid,
    input  logic        read_index,
    output logic [8:0]  read_address,
    input  logic [7:0]  read_value,
    output logic        valid_pixel,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        wave_display_idle
);

    logic [10:0] x_off;
    logic [7:0]  idx;
    logic        in_region;
    logic        buf_sel;

    logic        region_r;
    logic [7:0]  idx_r;
    logic [7:0]  yv_r;
    logic [7:0]  cur_sample;
    logic [7:0]  prev_sample;
    logic [7:0]  cur_idx;
    logic        first_col;

    logic        new_col;
    logic [7:0]  cmp_prev;
    logic [7:0]  cmp_cur;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic        hit;
    logic        unused_bits;

    assign x_off        = x - X_START;
    assign idx          = x_off[8:1];
    assign in_region    = valid && (x >= X_START)
                       && ({1'b0, x} < ({1'b0, X_START} + 12'd512))
                       && (y < 10'd512);
    assign read_address = {buf_sel, idx};
    assign unused_bits  = ^{x_off[10:9], x_off[0], y[9], y[0]};

    // Each sample covers two columns; the second column reuses the stored segment.
    always_comb begin
        new_col  = first_col || (idx_r != cur_idx);
        cmp_prev = prev_sample;
        cmp_cur  = cur_sample;
        if (new_col) begin
            cmp_prev = first_col ? read_value : cur_sample;
            cmp_cur  = read_value;
        end
        lo  = (cmp_prev < cmp_cur) ? cmp_prev : cmp_cur;
        hi  = (cmp_prev < cmp_cur) ? cmp_cur : cmp_prev;
        hit = region_r && (yv_r >= lo) && (yv_r <= hi);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            region_r          <= 1'b0;
            idx_r             <= 8'd0;
            yv_r              <= 8'd0;
            cur_sample        <= 8'd0;
            prev_sample       <= 8'd0;
            cur_idx           <= 8'd0;
            first_col         <= 1'b1;
            valid_pixel       <= 1'b0;
            {r, g, b}         <= 24'd0;
            wave_display_idle <= 1'b0;
            buf_sel           <= 1'b0;
        end else begin
            region_r <= in_region;
            idx_r    <= idx;
            yv_r     <= 8'd255 - y[8:1];

            if (region_r && new_col) begin
                prev_sample <= cmp_prev;
                cur_sample  <= read_value;
                cur_idx     <= idx_r;
                first_col   <= 1'b0;
            end else if (!region_r) begin
                first_col <= 1'b1;
            end

            valid_pixel <= region_r;
            if (hit)
                {r, g, b} <= WAVE_COLOR;
            else if (region_r)
                {r, g, b} <= BG_COLOR;
            else
                {r, g, b} <= 24'd0;

            // Buffer half is only re-latched during blanking so a frame never tears.
            wave_display_idle <= ~valid | (y >= 10'd512);
            if (wave_display_idle)
                buf_sel <= read_index;
        end
    end

endmodule

// File: tb/tb_wave_display.sv
// tb/tb_wave_display.sv - directed self-checking bench for wave_display
module tb_wave_display;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] x;
    logic [9:0]  y;
    logic        valid;
    logic        read_index;
    logic [8:0]  read_address;
    logic [7:0]  read_value;
    logic        valid_pixel;
    logic [7:0]  r, g, b;
    logic        wave_display_idle;

    logic [7:0]  mem [0:511];
    int          total = 0;
    int          bad = 0;

    logic        p_chk [2];
    logic [24:0] p_exp [2];
    string       p_tag [2];

    always #5 clk = ~clk;

    always @(posedge clk) read_value <= mem[read_address];

    wave_display dut (
        .clk              (clk),
        .reset            (rst_n),
        .x                (x),
        .y                (y),
        .valid            (valid),
        .read_index       (read_index),
        .read_address     (read_address),
        .read_value       (read_value),
        .valid_pixel      (valid_pixel),
        .r                (r),
        .g                (g),
        .b                (b),
        .wave_display_idle(wave_display_idle)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected {valid_pixel, rgb} for a contiguous left-to-right sweep of one row.
    function automatic logic [24:0] model(input int xi, input int yi, input int half);
        int         i;
        logic [7:0] yv, cur, prev, lo, hi;
        if (xi < 256 || xi > 767 || yi > 511) return 25'd0;
        i    = (xi - 256) / 2;
        yv   = 8'(255 - yi / 2);
        cur  = mem[half * 256 + i];
        prev = (i == 0) ? cur : mem[half * 256 + i - 1];
        lo   = (prev < cur) ? prev : cur;
        hi   = (prev < cur) ? cur : prev;
        if (yv >= lo && yv <= hi) return {1'b1, 24'hFFFFFF};
        return {1'b1, 24'h000000};
    endfunction

    task automatic clear_pipe();
        for (int k = 0; k < 2; k++) begin
            p_chk[k] = 1'b0;
            p_exp[k] = 25'd0;
            p_tag[k] = "";
        end
    endtask

    // Called at a negedge: presents one pixel, then checks the pixel presented two cycles ago.
    task automatic cyc(input int xi, input int yi, input logic vi, input logic chk,
                       input logic [24:0] ev, input string tag);
        p_chk[1] = p_chk[0];
        p_exp[1] = p_exp[0];
        p_tag[1] = p_tag[0];
        p_chk[0] = chk;
        p_exp[0] = ev;
        p_tag[0] = tag;
        x     = 11'(xi);
        y     = 10'(yi);
        valid = vi;
        @(negedge clk);
        if (p_chk[1]) check(p_tag[1], {7'd0, valid_pixel, r, g, b}, {7'd0, p_exp[1]});
    endtask

    task automatic idle_n(input int n);
        for (int k = 0; k < n; k++) cyc(0, 600, 1'b0, 1'b1, 25'd0, "blank");
    endtask

    task automatic row_part(input int yi, input int half, input int x0, input int x1);
        for (int xi = x0; xi <= x1; xi++)
            cyc(xi, yi, 1'b1, 1'b1, model(xi, yi, half), $sformatf("px x=%0d y=%0d", xi, yi));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        x          = 11'd0;
        y          = 10'd0;
        valid      = 1'b0;
        read_index = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i]       = 8'd128;
            mem[256 + i] = 8'(i);
        end
        clear_pipe();

        repeat (2) @(negedge clk);
        check("rst_vp", valid_pixel, 0);
        check("rst_rgb", {r, g, b}, 0);
        check("rst_idle", wave_display_idle, 0);
        check("rst_bufsel", read_address[8], 0);
        rst_n = 1'b1;

        // Flat 128 in half 0: yv=128 row is all trace, yv=205 row all background.
        idle_n(4);
        row_part(254, 0, 250, 770);
        idle_n(4);
        row_part(100, 0, 250, 770);
        idle_n(4);

        // Ramp in half 1: bottom and top rows.
        read_index = 1'b1;
        idle_n(4);
        check("bufsel_half1", read_address[8], 1);
        row_part(511, 1, 250, 770);
        idle_n(4);
        row_part(1, 1, 250, 770);
        idle_n(4);

        // Step 20 -> 60 at samples 10/11: yv 20, 40, 60 hit at x=278/279, 61 does not.
        mem[256 + 10] = 8'd20;
        mem[256 + 11] = 8'd60;
        row_part(470, 1, 250, 300);
        idle_n(3);
        row_part(430, 1, 250, 300);
        idle_n(3);
        row_part(390, 1, 250, 300);
        idle_n(3);
        row_part(388, 1, 250, 300);
        idle_n(4);

        // read_index change mid-frame is ignored until blanking.
        for (int k = 0; k < 3; k++) cyc(300, 10, 1'b1, 1'b0, 25'd0, "act");
        read_index = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc(300, 10, 1'b1, 1'b0, 25'd0, "act");
            check("bufsel_hold", read_address[8], 1);
            check("idle_low", wave_display_idle, 0);
        end
        cyc(0, 600, 1'b0, 1'b0, 25'd0, "blank");
        check("idle_rise", wave_display_idle, 1);
        check("bufsel_pre_swap", read_address[8], 1);
        cyc(0, 600, 1'b0, 1'b0, 25'd0, "blank");
        check("bufsel_swap", read_address[8], 0);

        // Mid-row asynchronous reset.
        read_index = 1'b1;
        idle_n(4);
        check("bufsel_pre_rst", read_address[8], 1);
        row_part(254, 1, 250, 400);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_vp", valid_pixel, 0);
        check("rst_async_rgb", {r, g, b}, 0);
        check("rst_async_bufsel", read_address[8], 0);
        clear_pipe();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(256, 254, 1'b1, 1'b1, model(256, 254, 0), "post_rst x=256");
        check("post_rst_lat1", {valid_pixel, r, g, b}, 0);
        row_part(254, 0, 257, 770);
        check("bufsel_after_rst", read_address[8], 0);
        idle_n(4);
        check("bufsel_after_idle", read_address[8], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
